id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline, directly downstream of fetch.
- Contains the IF/ID pipeline register, main decoder, 32x32 register file with write-through bypass, and load-use hazard detection.
- Launches the registered ID/EX bundle toward execute.
- Returns a stall to the PC register and accepts a flush from the PC mux select (PCSrc).

Parameters:
- DATA_W, 32, datapath and instruction width
- NREGS, 32, register file depth; address width is 5

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- if_instr  in  32  instruction from instruction memory
- if_pc4  in  32  PC+4 from fetch adder
- if_valid  in  1  fetch output is meaningful
- flush  in  1  taken branch/jump (PCSrc); kill younger instructions
- ex_memread  in  1  instruction currently in EX is a load
- ex_rt  in  5  destination register of that load
- wb_we  in  1  writeback enable
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback data
- stall  out  1  combinational; hold PC and IF/ID
- id_ex_valid  out  1  registered
- id_ex_pc4  out  32  registered
- id_ex_rs_data, id_ex_rt_data  out  32 each  registered operands
- id_ex_imm  out  32  registered, sign-extended instr[15:0]
- id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  registered
- id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_alusrc, id_ex_regdst, id_ex_branch  out  1 each  registered controls
- id_ex_aluop  out  2  registered
- id_ex_illegal  out  1  registered; unsupported opcode

Behaviour:
- Reset (reset=0, async):
  - IF/ID: instr=0, pc4=0, valid=0.
  - Every ID/EX output = 0.
  - All 32 registers = 0.
  - Once released, the first capture happens on the next rising edge.
- Latency:
  - Instruction sampled into IF/ID at edge N.
  - Its decode appears on id_ex_* after edge N+1.
- IF/ID update priority, highest first:
  - flush: valid=0, instr=0.
  - stall: hold.
  - otherwise: load if_instr, if_pc4, if_valid.
- ID/EX update:
  - If flush, stall, or IF/ID valid=0: bubble (valid=0, all controls 0, illegal=0; data fields don't-care but driven 0).
  - Otherwise: decoded values with valid=1.
- Decode, by op=instr[31:26]; rs=[25:21], rt=[20:16], rd=[15:11]:
  - op 0 (R-type): regdst=1, regwrite=1, aluop=10.
  - op 35 (lw): alusrc=1, memtoreg=1, regwrite=1, memread=1, aluop=00.
  - op 43 (sw): alusrc=1, memwrite=1, aluop=00.
  - op 4 (beq): branch=1, aluop=01.
  - op 8 (addi): alusrc=1, regwrite=1, aluop=00.
  - Any other op: all controls 0, illegal=1.
- Register file:
  - Written at posedge when wb_we=1 and wb_addr!=0.
  - r0 always reads 0.
  - Reads are combinational from IF/ID rs/rt.
  - Bypass: if wb_we=1, wb_addr!=0 and wb_addr equals the read address, the read returns wb_data in the same cycle.
- Hazard detection:
  - uses_rt = (op is 0, 4 or 43).
  - stall = ifid_valid & ex_memread & (ex_rt!=0) & ((ex_rt==rs) | (uses_rt & ex_rt==rt)).
  - stall is forced to 0 when flush=1.
- Simultaneous flush and stall: flush wins; stall output is 0.
- A writeback to a register in the same cycle as an ID/EX capture: the captured operand reflects wb_data via the bypass.

Test Plan:
- Reset released; feed if_instr=0x2008_0005 (addi $8,$0,5), if_valid=1 -> two edges later id_ex_valid=1, alusrc=1, regwrite=1, imm=0x0000_0005, rt=8.
- Write wb r9=0xDEAD_BEEF at the edge where add $10,$9,$9 is in IF/ID -> id_ex_rs_data = id_ex_rt_data = 0xDEAD_BEEF (bypass); writing r0 with 0x1234 then reading r0 -> 0.
- ex_memread=1, ex_rt=9 while IF/ID holds add $10,$9,$0 -> stall=1 for one cycle, IF/ID held, ID/EX bubble (valid=0); next cycle with ex_memread=0 the add issues with valid=1.
- flush=1 coincident with a stall condition -> stall=0, IF/ID valid=0, ID/EX bubble; the instruction on if_instr is dropped.
- if_instr=0xFC00_0000 (op 63) -> id_ex_illegal=1, all controls 0; sw $5,-4($6) -> memwrite=1, imm=0xFFFF_FFFC, regwrite=0.
- Assert reset mid-stream with non-zero registers -> all outputs and registers 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage of the 5-stage MIPS pipeline.
// Contents: the IF/ID register, the main decoder, and a 32-entry register file
// with write-through bypass. It also detects load-use hazards and drives the
// registered ID/EX bundle toward execute.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc4,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_ex_valid,
  output logic [DATA_W-1:0] id_ex_pc4,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic [4:0]        id_ex_rd,
  output logic              id_ex_regwrite,
  output logic              id_ex_memread,
  output logic              id_ex_memwrite,
  output logic              id_ex_memtoreg,
  output logic              id_ex_alusrc,
  output logic              id_ex_regdst,
  output logic              id_ex_branch,
  output logic [1:0]        id_ex_aluop,
  output logic              id_ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  logic [DATA_W-1:0] ifid_instr;
  logic [DATA_W-1:0] ifid_pc4;
  logic              ifid_valid;
  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        op;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              c_regwrite, c_memread, c_memwrite, c_memtoreg;
  logic              c_alusrc, c_regdst, c_branch, c_illegal;
  logic [1:0]        c_aluop;
  logic              uses_rt;
  logic              issue;

  assign op      = ifid_instr[31:26];
  assign rs      = ifid_instr[25:21];
  assign rt      = ifid_instr[20:16];
  assign rd      = ifid_instr[15:11];
  assign imm_ext = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};

  // IF/ID register: flush kills, stall holds, otherwise load from fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (flush) begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_instr <= if_instr;
      ifid_pc4   <= if_pc4;
      ifid_valid <= if_valid;
    end
  end

  // Register file write port; r0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass so ID never sees a stale value
  always_comb begin
    rs_data = regs[rs];
    rt_data = regs[rt];
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) rs_data = wb_data;
    if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) rt_data = wb_data;
    if (rs == 5'd0) rs_data = '0;
    if (rt == 5'd0) rt_data = '0;
  end

  // Main decoder
  always_comb begin
    c_regwrite = 1'b0;
    c_memread  = 1'b0;
    c_memwrite = 1'b0;
    c_memtoreg = 1'b0;
    c_alusrc   = 1'b0;
    c_regdst   = 1'b0;
    c_branch   = 1'b0;
    c_aluop    = 2'b00;
    c_illegal  = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        c_regdst   = 1'b1;
        c_regwrite = 1'b1;
        c_aluop    = 2'b10;
      end
      OP_LW: begin
        c_alusrc   = 1'b1;
        c_memtoreg = 1'b1;
        c_regwrite = 1'b1;
        c_memread  = 1'b1;
      end
      OP_SW: begin
        c_alusrc   = 1'b1;
        c_memwrite = 1'b1;
      end
      OP_BEQ: begin
        c_branch = 1'b1;
        c_aluop  = 2'b01;
      end
      OP_ADDI: begin
        c_alusrc   = 1'b1;
        c_regwrite = 1'b1;
      end
      default: c_illegal = 1'b1;
    endcase
  end

  // Load-use hazard; a flush overrides it since the dependent instruction dies anyway
  always_comb begin
    uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    stall   = ifid_valid && ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == rs) || (uses_rt && (ex_rt == rt))) && !flush;
  end

  assign issue = ifid_valid && !flush && !stall;

  // ID/EX register: decoded bundle when issuing, an all-zero bubble otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc4      <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_alusrc   <= 1'b0;
      id_ex_regdst   <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_aluop    <= 2'b00;
      id_ex_illegal  <= 1'b0;
    end else if (issue) begin
      id_ex_valid    <= 1'b1;
      id_ex_pc4      <= ifid_pc4;
      id_ex_rs_data  <= rs_data;
      id_ex_rt_data  <= rt_data;
      id_ex_imm      <= imm_ext;
      id_ex_rs       <= rs;
      id_ex_rt       <= rt;
      id_ex_rd       <= rd;
      id_ex_regwrite <= c_regwrite;
      id_ex_memread  <= c_memread;
      id_ex_memwrite <= c_memwrite;
      id_ex_memtoreg <= c_memtoreg;
      id_ex_alusrc   <= c_alusrc;
      id_ex_regdst   <= c_regdst;
      id_ex_branch   <= c_branch;
      id_ex_aluop    <= c_aluop;
      id_ex_illegal  <= c_illegal;
    end else begin
      id_ex_valid    <= 1'b0;
      id_ex_pc4      <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_alusrc   <= 1'b0;
      id_ex_regdst   <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_aluop    <= 2'b00;
      id_ex_illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: each task drives one scenario and checks inline.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instr, if_pc4;
  logic        if_valid, flush, ex_memread;
  logic [4:0]  ex_rt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, id_ex_valid;
  logic [31:0] id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
  logic        id_ex_alusrc, id_ex_regdst, id_ex_branch, id_ex_illegal;
  logic [1:0]  id_ex_aluop;
  logic [9:0]  ctrl;

  int vectors = 0;
  int miscompares = 0;

  // {regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop, illegal}
  localparam logic [9:0] C_ADDI = 10'b1000100000;
  localparam logic [9:0] C_RTYP = 10'b1000010100;
  localparam logic [9:0] C_LW   = 10'b1101100000;
  localparam logic [9:0] C_SW   = 10'b0010100000;
  localparam logic [9:0] C_BEQ  = 10'b0000001010;
  localparam logic [9:0] C_ILL  = 10'b0000000001;

  localparam logic [31:0] I_ADDI8  = 32'h2008_0005; // addi $8,$0,5
  localparam logic [31:0] I_ADD99  = 32'h0129_5020; // add $10,$9,$9
  localparam logic [31:0] I_ADD90  = 32'h0120_5020; // add $10,$9,$0
  localparam logic [31:0] I_ADD00  = 32'h0000_5820; // add $11,$0,$0
  localparam logic [31:0] I_SW     = 32'hACC5_FFFC; // sw $5,-4($6)
  localparam logic [31:0] I_LW     = 32'h8C07_0008; // lw $7,8($0)
  localparam logic [31:0] I_BEQ    = 32'h1022_0003; // beq $1,$2,3
  localparam logic [31:0] I_ILL    = 32'hFC00_0000;

  assign ctrl = {id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg,
                 id_ex_alusrc, id_ex_regdst, id_ex_branch, id_ex_aluop, id_ex_illegal};

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc4(if_pc4), .if_valid(if_valid),
    .flush(flush), .ex_memread(ex_memread), .ex_rt(ex_rt), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .id_ex_valid(id_ex_valid),
    .id_ex_pc4(id_ex_pc4), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_alusrc(id_ex_alusrc), .id_ex_regdst(id_ex_regdst), .id_ex_branch(id_ex_branch),
    .id_ex_aluop(id_ex_aluop), .id_ex_illegal(id_ex_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] instr, input logic [31:0] pc4, input logic v);
    if_instr = instr;
    if_pc4   = pc4;
    if_valid = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    feed(32'h0, 32'h0, 1'b0);
    flush = 0; ex_memread = 0; ex_rt = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    #12;
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", id_ex_valid); end
    vectors++; if (ctrl !== 10'b0) begin miscompares++; $display("FAIL reset_ctrl got=%b exp=0", ctrl); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall); end
    reset = 1'b1;
  endtask

  task automatic test_addi_latency();
    feed(I_ADDI8, 32'h0000_0004, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL addi_early got=%b exp=0", id_ex_valid); end
    tick();
    vectors++; if (id_ex_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got=%b exp=1", id_ex_valid); end
    vectors++; if (ctrl !== C_ADDI) begin miscompares++; $display("FAIL addi_ctrl got=%b exp=%b", ctrl, C_ADDI); end
    vectors++; if (id_ex_imm !== 32'h5) begin miscompares++; $display("FAIL addi_imm got=%h exp=00000005", id_ex_imm); end
    vectors++; if (id_ex_rt !== 5'd8) begin miscompares++; $display("FAIL addi_rt got=%0d exp=8", id_ex_rt); end
    vectors++; if (id_ex_pc4 !== 32'h4) begin miscompares++; $display("FAIL addi_pc4 got=%h exp=00000004", id_ex_pc4); end
    tick();
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL addi_bubble got=%b exp=0", id_ex_valid); end
  endtask

  task automatic test_bypass();
    feed(I_ADD99, 32'h8, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_we = 0;
    vectors++; if (id_ex_rs_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL byp_rs got=%h exp=deadbeef", id_ex_rs_data); end
    vectors++; if (id_ex_rt_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL byp_rt got=%h exp=deadbeef", id_ex_rt_data); end
    vectors++; if (ctrl !== C_RTYP) begin miscompares++; $display("FAIL byp_ctrl got=%b exp=%b", ctrl, C_RTYP); end
    vectors++; if (id_ex_rd !== 5'd10) begin miscompares++; $display("FAIL byp_rd got=%0d exp=10", id_ex_rd); end
    // r9 must now be held in the array
    feed(I_ADD99, 32'hC, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 0;
    vectors++; if (id_ex_rs_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rf_r9 got=%h exp=deadbeef", id_ex_rs_data); end
    feed(I_ADD00, 32'h10, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    wb_we = 1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    wb_we = 0;
    vectors++; if (id_ex_rs_data !== 32'h0) begin miscompares++; $display("FAIL r0_rs got=%h exp=0", id_ex_rs_data); end
    vectors++; if (id_ex_rt_data !== 32'h0) begin miscompares++; $display("FAIL r0_rt got=%h exp=0", id_ex_rt_data); end
  endtask

  task automatic test_load_use();
    feed(I_ADD90, 32'h20, 1'b1);
    tick();
    ex_memread = 1; ex_rt = 5'd9;
    feed(I_ADDI8, 32'h24, 1'b1);
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got=%b exp=0", id_ex_valid); end
    ex_memread = 0;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_release got=%b exp=0", stall); end
    tick();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_rs !== 5'd9 || id_ex_rd !== 5'd10) begin
      miscompares++; $display("FAIL lu_issue got=v%b rs%0d rd%0d exp=v1 rs9 rd10", id_ex_valid, id_ex_rs, id_ex_rd); end
    vectors++; if (id_ex_pc4 !== 32'h20) begin miscompares++; $display("FAIL lu_pc4 got=%h exp=00000020", id_ex_pc4); end
    // addi $8 now in IF/ID: a load to $8 only matters through rs for addi
    ex_memread = 1; ex_rt = 5'd8;
    feed(32'h0, 32'h0, 1'b0);
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_rt_unused got=%b exp=0", stall); end
    tick();
    ex_memread = 0; ex_rt = 0;
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_rt !== 5'd8 || ctrl !== C_ADDI) begin
      miscompares++; $display("FAIL lu_next got=v%b rt%0d ctrl%b exp=v1 rt8 ctrl%b", id_ex_valid, id_ex_rt, ctrl, C_ADDI); end
  endtask

  task automatic test_flush_stall();
    feed(I_ADD90, 32'h30, 1'b1);
    tick();
    ex_memread = 1; ex_rt = 5'd9; flush = 1;
    feed(I_ADDI8, 32'h34, 1'b1);
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fl_stall got=%b exp=0", stall); end
    tick();
    vectors++; if (id_ex_valid !== 1'b0) begin miscompares++; $display("FAIL fl_bubble got=%b exp=0", id_ex_valid); end
    flush = 0; ex_memread = 0; ex_rt = 0;
    feed(32'h0, 32'h0, 1'b0);
    tick();
    vectors++; if (id_ex_valid !== 1'b0 || ctrl !== 10'b0) begin
      miscompares++; $display("FAIL fl_dropped got=v%b ctrl%b exp=v0 ctrl0", id_ex_valid, ctrl); end
  endtask

  task automatic test_back_to_back();
    feed(I_ILL, 32'h40, 1'b1);
    tick();
    feed(I_SW, 32'h44, 1'b1);
    tick();
    vectors++; if (ctrl !== C_ILL || id_ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL ill got=v%b ctrl%b exp=v1 ctrl%b", id_ex_valid, ctrl, C_ILL); end
    feed(I_LW, 32'h48, 1'b1);
    tick();
    vectors++; if (ctrl !== C_SW) begin miscompares++; $display("FAIL sw_ctrl got=%b exp=%b", ctrl, C_SW); end
    vectors++; if (id_ex_imm !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL sw_imm got=%h exp=fffffffc", id_ex_imm); end
    vectors++; if (id_ex_rs !== 5'd6 || id_ex_rt !== 5'd5) begin
      miscompares++; $display("FAIL sw_regs got=rs%0d rt%0d exp=rs6 rt5", id_ex_rs, id_ex_rt); end
    feed(I_BEQ, 32'h4C, 1'b1);
    tick();
    vectors++; if (ctrl !== C_LW || id_ex_imm !== 32'h8) begin
      miscompares++; $display("FAIL lw got=ctrl%b imm%h exp=ctrl%b imm00000008", ctrl, id_ex_imm, C_LW); end
    feed(32'h0, 32'h0, 1'b0);
    tick();
    vectors++; if (ctrl !== C_BEQ || id_ex_pc4 !== 32'h4C) begin
      miscompares++; $display("FAIL beq got=ctrl%b pc4%h exp=ctrl%b pc4 0000004c", ctrl, id_ex_pc4, C_BEQ); end
  endtask

  task automatic test_async_reset();
    feed(I_ADDI8, 32'h50, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    tick();
    vectors++; if (id_ex_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre got=%b exp=1", id_ex_valid); end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (id_ex_valid !== 1'b0 || ctrl !== 10'b0) begin
      miscompares++; $display("FAIL ar_outputs got=v%b ctrl%b exp=v0 ctrl0", id_ex_valid, ctrl); end
    vectors++; if (id_ex_imm !== 32'h0 || id_ex_pc4 !== 32'h0 || id_ex_rt !== 5'd0) begin
      miscompares++; $display("FAIL ar_data got=imm%h pc4%h rt%0d exp=0", id_ex_imm, id_ex_pc4, id_ex_rt); end
    @(negedge clk);
    reset = 1'b1;
    feed(I_ADD99, 32'h60, 1'b1);
    tick();
    feed(32'h0, 32'h0, 1'b0);
    tick();
    vectors++; if (id_ex_valid !== 1'b1 || id_ex_rs_data !== 32'h0 || id_ex_rt_data !== 32'h0) begin
      miscompares++; $display("FAIL ar_regs got=v%b rs%h rt%h exp=v1 rs0 rt0", id_ex_valid, id_ex_rs_data, id_ex_rt_data); end
  endtask

  initial begin
    test_reset();
    test_addi_latency();
    test_bypass();
    test_load_use();
    test_flush_stall();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
